note_table_loader: RTL and testbench
====================================

NOTE_TABLE_LOADER -- requirements
Module: note_table_loader

Interface
REQ-001 SHALL have parameter INIT_LENGTH, default 15: o_length value after reset (index of last entry of bank 0).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum idle cycles between bytes inside a frame.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_byte  input  8  loader byte, valid only when i_byte_stb=1.
REQ-006 SHALL have port i_byte_stb  input  1  one-cycle byte strobe; no backpressure.
REQ-007 SHALL have port i_rd_addr  input  5  note-table read address from the sequencer.
REQ-008 SHALL have port o_rd_data  output  16  entry at i_rd_addr in the active bank; bits [5:0] are the note and bits [10:6] are the length.
REQ-009 SHALL have port o_length  output  5  index of the last valid entry in the active bank.
REQ-010 SHALL have port o_bank  output  1  active bank number.
REQ-011 SHALL have port o_busy  output  1  high while a frame is in progress (state other than IDLE).
REQ-012 SHALL have port o_load_ok  output  1  one-cycle pulse when a frame is accepted.
REQ-013 SHALL have port o_load_err  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-014 SHALL hold two banks of 32x16 storage; the sequencer reads the active bank, and the loader writes only the inactive bank.
REQ-015 SHALL drive o_rd_data combinationally from i_rd_addr and o_bank, with zero-cycle read latency.
REQ-016 SHALL accept this frame format: header 0xA5, count N, 2N data bytes (low byte then high byte per entry), checksum byte.
REQ-017 SHALL define the checksum as the XOR of all 2N data bytes; header and count bytes are excluded.
REQ-018 SHALL implement FSM states IDLE, COUNT, LO, HI, CHECK.
REQ-019 IDLE: on a byte equal to 0xA5, SHALL go to COUNT; any other byte SHALL be ignored with no error.
REQ-020 COUNT: for N in 1..32, SHALL latch N-1, clear the entry index and checksum, and go to LO.
REQ-021 COUNT: for N=0 or N>32, SHALL pulse o_load_err and return to IDLE.
REQ-022 LO: SHALL latch the byte, XOR it into the checksum, and go to HI.
REQ-023 HI: SHALL write {byte, lo} to the inactive bank at the entry index in the same cycle, and XOR the byte into the checksum.
REQ-024 HI: if the entry index equals N-1, SHALL go to CHECK; otherwise it SHALL increment the index and go to LO.
REQ-025 CHECK, byte equals checksum: on the next cycle o_load_ok=1, o_bank toggled, o_length=N-1, state IDLE.
REQ-026 CHECK, byte differs from checksum: on the next cycle o_load_err=1, bank and length unchanged, state IDLE.
REQ-027 SHALL count cycles without i_byte_stb in states other than IDLE; at TIMEOUT_CYCLES it SHALL pulse o_load_err and return to IDLE.
REQ-028 SHALL reset the timeout counter on every byte; a byte arriving in the cycle the timeout would fire SHALL be processed and no timeout SHALL occur.
REQ-029 SHALL never drive o_load_ok and o_load_err high in the same cycle.
REQ-030 SHALL leave the active bank untouched by a partial or aborted frame; contents of the inactive bank are then undefined.
REQ-031 SHALL make a bank swap visible on o_rd_data in the same cycle o_bank changes; the sequencer handles mid-song swaps.
REQ-032 SHALL size the timeout counter as clog2(TIMEOUT_CYCLES+1) bits; the entry index is 5 bits and never wraps within a frame.

Reset
REQ-033 i_rst SHALL force state IDLE, o_bank=0, o_length=INIT_LENGTH, o_busy=0, o_load_ok=0, o_load_err=0, index=0, checksum=0, timeout counter=0.
REQ-034 Reset mid-frame SHALL abort silently: no pulse, no swap.
REQ-035 Reset SHALL NOT clear storage contents.
REQ-036 Reset SHALL take priority over i_byte_stb in the same cycle.

Verification
REQ-037 Good frame: A5,02,41,00,82,01,C2 -> o_load_ok one cycle after C2; o_bank=1; o_length=1; i_rd_addr=0 gives 0x0041; i_rd_addr=1 gives 0x0182.
REQ-038 Bad checksum: the same frame ending in C3 -> o_load_err one cycle after; o_bank=0; o_length=15; o_rd_data of bank 0 unchanged.
REQ-039 Count errors: A5,00 and then A5,21 -> o_load_err after each count byte; o_busy=0 next cycle.
REQ-040 Timeout: A5,01,10, then silence for TIMEOUT_CYCLES (set to 8 in test) -> o_load_err, IDLE; a byte at cycle 8 instead -> no error.
REQ-041 Noise and reset: 00,FF before A5 ignored; i_rst asserted mid-data -> no pulses, o_bank=0, o_length=15, and the next good frame loads normally.
REQ-042 Two consecutive good frames -> o_bank goes 0, 1, 0; the second frame writes bank 0 while bank 1 stays readable throughout.

Source files
------------

// File: rtl/note_table_loader.sv
// Double-buffered 32x16 note table loaded from a framed byte stream.
// The sequencer reads the active bank while frames fill the other one.
module note_table_loader #(
    parameter int INIT_LENGTH    = 15,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_stb,
    input  logic [4:0]  i_rd_addr,
    output logic [15:0] o_rd_data,
    output logic [4:0]  o_length,
    output logic        o_bank,
    output logic        o_busy,
    output logic        o_load_ok,
    output logic        o_load_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0] LEN_RST = 5'(INIT_LENGTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_LO,
        S_HI,
        S_CHECK
    } state_t;

    state_t        state, state_n;
    logic [4:0]    idx, idx_n;
    logic [4:0]    last, last_n;
    logic [7:0]    csum, csum_n;
    logic [7:0]    lo, lo_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          bank, bank_n;
    logic [4:0]    len, len_n;
    logic          ok, ok_n;
    logic          err, err_n;
    logic          we;

    logic [15:0] mem0 [32];
    logic [15:0] mem1 [32];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
            idx   <= '0;
            last  <= '0;
            csum  <= '0;
            lo    <= '0;
            tcnt  <= '0;
            bank  <= 1'b0;
            len   <= LEN_RST;
            ok    <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            last  <= last_n;
            csum  <= csum_n;
            lo    <= lo_n;
            tcnt  <= tcnt_n;
            bank  <= bank_n;
            len   <= len_n;
            ok    <= ok_n;
            err   <= err_n;
        end
    end

    // Storage survives reset; only the inactive bank is ever written.
    always_ff @(posedge i_clk) begin
        if (we) begin
            if (bank) begin
                mem0[idx] <= {i_byte, lo};
            end else begin
                mem1[idx] <= {i_byte, lo};
            end
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        last_n  = last;
        csum_n  = csum;
        lo_n    = lo;
        tcnt_n  = tcnt;
        bank_n  = bank;
        len_n   = len;
        ok_n    = 1'b0;
        err_n   = 1'b0;
        we      = 1'b0;
        if (state != S_IDLE && !i_byte_stb) begin
            if (tcnt == T_LAST) begin
                err_n   = 1'b1;
                state_n = S_IDLE;
                tcnt_n  = '0;
            end else begin
                tcnt_n = tcnt + 1'b1;
            end
        end else begin
            tcnt_n = '0;
            if (i_byte_stb) begin
                unique case (state)
                    S_IDLE: begin
                        if (i_byte == 8'hA5) state_n = S_COUNT;
                    end
                    S_COUNT: begin
                        if (i_byte != 8'd0 && i_byte <= 8'd32) begin
                            last_n  = i_byte[4:0] - 5'd1;
                            idx_n   = '0;
                            csum_n  = '0;
                            state_n = S_LO;
                        end else begin
                            err_n   = 1'b1;
                            state_n = S_IDLE;
                        end
                    end
                    S_LO: begin
                        lo_n    = i_byte;
                        csum_n  = csum ^ i_byte;
                        state_n = S_HI;
                    end
                    S_HI: begin
                        we     = !i_rst;
                        csum_n = csum ^ i_byte;
                        if (idx == last) begin
                            state_n = S_CHECK;
                        end else begin
                            idx_n   = idx + 5'd1;
                            state_n = S_LO;
                        end
                    end
                    S_CHECK: begin
                        state_n = S_IDLE;
                        if (i_byte == csum) begin
                            ok_n   = 1'b1;
                            bank_n = ~bank;
                            len_n  = last;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                    default: state_n = S_IDLE;
                endcase
            end
        end
    end

    assign o_rd_data  = bank ? mem1[i_rd_addr] : mem0[i_rd_addr];
    assign o_length   = len;
    assign o_bank     = bank;
    assign o_busy     = (state != S_IDLE);
    assign o_load_ok  = ok;
    assign o_load_err = err;

endmodule

// File: tb/tb_note_table_loader.sv
// Directed vector bench for note_table_loader.
// Inputs change on negedge; outputs are checked 1ns after posedge.
module tb_note_table_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = '0;
    logic        stb = 1'b0;
    logic [4:0]  addr = '0;
    logic [15:0] rd_data;
    logic [4:0]  length;
    logic        bank;
    logic        busy;
    logic        load_ok;
    logic        load_err;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    note_table_loader #(
        .INIT_LENGTH(15),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_byte(din),
        .i_byte_stb(stb),
        .i_rd_addr(addr),
        .o_rd_data(rd_data),
        .o_length(length),
        .o_bank(bank),
        .o_busy(busy),
        .o_load_ok(load_ok),
        .o_load_err(load_err)
    );

    typedef struct {
        bit          r;
        bit          s;
        logic [7:0]  b;
        logic [4:0]  a;
        bit          ok;
        bit          er;
        bit          bk;
        logic [4:0]  ln;
        bit          bz;
        bit          c;
        logic [15:0] d;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input bit r, input bit s, input logic [7:0] b,
        input logic [4:0] a, input bit ok, input bit er,
        input bit bk, input logic [4:0] ln, input bit bz,
        input bit c, input logic [15:0] d);
        vec_t v;
        v.r = r; v.s = s; v.b = b; v.a = a;
        v.ok = ok; v.er = er; v.bk = bk; v.ln = ln;
        v.bz = bz; v.c = c; v.d = d;
        return v;
    endfunction

    task automatic run(input string name, input vec_t v);
        bit bad;
        @(negedge clk);
        rst  = v.r;
        stb  = v.s;
        din  = v.b;
        addr = v.a;
        @(posedge clk);
        #1;
        n_run++;
        bad = (load_ok !== v.ok) || (load_err !== v.er) ||
              (bank !== v.bk) || (length !== v.ln) ||
              (busy !== v.bz) || (v.c && rd_data !== v.d);
        if (bad) begin
            n_fail++;
            $display("FAIL %s: got ok=%0b err=%0b bank=%0b len=%0d busy=%0b data=%h want ok=%0b err=%0b bank=%0b len=%0d busy=%0b data=%h (chk=%0b)",
                     name, load_ok, load_err, bank, length, busy, rd_data,
                     v.ok, v.er, v.bk, v.ln, v.bz, v.d, v.c);
        end
    endtask

    // strobed byte, no reset
    function automatic vec_t sb(input logic [7:0] b, input logic [4:0] a,
        input bit ok, input bit er, input bit bk, input logic [4:0] ln,
        input bit bz, input bit c, input logic [15:0] d);
        return mk(1'b0, 1'b1, b, a, ok, er, bk, ln, bz, c, d);
    endfunction

    initial begin
        // reset, including reset winning over a strobe
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 15, 0, 0, 0));
        tv.push_back(mk(1, 1, 8'hA5, 0, 0, 0, 0, 15, 0, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 15, 0, 0, 0));
        // good frame into bank 1
        tv.push_back(sb(8'hA5, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(sb(8'h02, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(sb(8'h41, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(sb(8'h00, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(sb(8'h82, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(sb(8'h01, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(sb(8'hC2, 0, 1, 0, 1, 1, 0, 1, 16'h0041));
        tv.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 1, 0, 1, 16'h0182));
        // second frame into bank 0, bank 1 readable throughout
        tv.push_back(sb(8'hA5, 0, 0, 0, 1, 1, 1, 1, 16'h0041));
        tv.push_back(sb(8'h03, 0, 0, 0, 1, 1, 1, 1, 16'h0041));
        tv.push_back(sb(8'h34, 0, 0, 0, 1, 1, 1, 1, 16'h0041));
        tv.push_back(sb(8'h12, 0, 0, 0, 1, 1, 1, 1, 16'h0041));
        tv.push_back(sb(8'hBC, 1, 0, 0, 1, 1, 1, 1, 16'h0182));
        tv.push_back(sb(8'h0A, 1, 0, 0, 1, 1, 1, 1, 16'h0182));
        tv.push_back(sb(8'hFF, 0, 0, 0, 1, 1, 1, 1, 16'h0041));
        tv.push_back(sb(8'h07, 0, 0, 0, 1, 1, 1, 1, 16'h0041));
        tv.push_back(sb(8'h68, 0, 1, 0, 0, 2, 0, 1, 16'h1234));
        tv.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 2, 0, 1, 16'h0ABC));
        tv.push_back(mk(0, 0, 8'h00, 2, 0, 0, 0, 2, 0, 1, 16'h07FF));
        // reset keeps storage
        tv.push_back(mk(1, 0, 8'h00, 2, 0, 0, 0, 15, 0, 1, 16'h07FF));
        tv.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 15, 0, 1, 16'h1234));
        // bad checksum: active bank 0 untouched
        tv.push_back(sb(8'hA5, 0, 0, 0, 0, 15, 1, 1, 16'h1234));
        tv.push_back(sb(8'h02, 0, 0, 0, 0, 15, 1, 1, 16'h1234));
        tv.push_back(sb(8'h41, 0, 0, 0, 0, 15, 1, 1, 16'h1234));
        tv.push_back(sb(8'h00, 0, 0, 0, 0, 15, 1, 1, 16'h1234));
        tv.push_back(sb(8'h82, 0, 0, 0, 0, 15, 1, 1, 16'h1234));
        tv.push_back(sb(8'h01, 0, 0, 0, 0, 15, 1, 1, 16'h1234));
        tv.push_back(sb(8'hC3, 0, 0, 1, 0, 15, 0, 1, 16'h1234));
        tv.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 15, 0, 1, 16'h0ABC));
        // count errors N=0 and N=33
        tv.push_back(sb(8'hA5, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(sb(8'h00, 0, 0, 1, 0, 15, 0, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 15, 0, 0, 0));
        tv.push_back(sb(8'hA5, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(sb(8'h21, 0, 0, 1, 0, 15, 0, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 15, 0, 0, 0));
        // N=32 accepted, then silent reset abort
        tv.push_back(sb(8'hA5, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(sb(8'h20, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 15, 0, 0, 0));
        // noise ignored, reset mid-data, then a normal load
        tv.push_back(sb(8'h00, 0, 0, 0, 0, 15, 0, 0, 0));
        tv.push_back(sb(8'hFF, 0, 0, 0, 0, 15, 0, 0, 0));
        tv.push_back(sb(8'hA5, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(sb(8'h02, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(sb(8'h11, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(mk(1, 1, 8'h22, 0, 0, 0, 0, 15, 0, 1, 16'h1234));
        tv.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 15, 0, 1, 16'h1234));
        tv.push_back(sb(8'hA5, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(sb(8'h02, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(sb(8'h41, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(sb(8'h00, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(sb(8'h82, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(sb(8'h01, 0, 0, 0, 0, 15, 1, 0, 0));
        tv.push_back(sb(8'hC2, 0, 1, 0, 1, 1, 0, 1, 16'h0041));
        tv.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 1, 0, 1, 16'h0182));

        foreach (tv[i]) run($sformatf("vec%0d", i), tv[i]);

        // timeout: 8 silent cycles inside a frame
        run("to_a5", sb(8'hA5, 0, 0, 0, 1, 1, 1, 1, 16'h0041));
        run("to_n", sb(8'h01, 0, 0, 0, 1, 1, 1, 1, 16'h0041));
        run("to_lo", sb(8'h10, 0, 0, 0, 1, 1, 1, 1, 16'h0041));
        for (int i = 1; i <= 8; i++) begin
            run($sformatf("to_idle%0d", i),
                mk(0, 0, 8'h00, 0, 0, i == 8, 1, 1, i < 8, 1, 16'h0041));
        end
        run("to_after", mk(0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 1, 16'h0041));

        // byte lands exactly on the timeout cycle
        run("tb_a5", sb(8'hA5, 0, 0, 0, 1, 1, 1, 1, 16'h0041));
        run("tb_n", sb(8'h01, 0, 0, 0, 1, 1, 1, 1, 16'h0041));
        run("tb_lo", sb(8'h10, 0, 0, 0, 1, 1, 1, 1, 16'h0041));
        for (int i = 1; i <= 7; i++) begin
            run($sformatf("tb_idle%0d", i),
                mk(0, 0, 8'h00, 0, 0, 0, 1, 1, 1, 1, 16'h0041));
        end
        run("tb_hi8", sb(8'h20, 0, 0, 0, 1, 1, 1, 1, 16'h0041));
        run("tb_chk", sb(8'h30, 0, 1, 0, 0, 0, 0, 1, 16'h2010));
        run("tb_end", mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 16'h2010));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

endmodule
